// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters.
module alu_arbiter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [6:0]           req0_funct7,
    input  logic [2:0]           req0_funct3,
    input  logic [WORD_SIZE-1:0] req0_src1,
    input  logic [WORD_SIZE-1:0] req0_src2,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [6:0]           req1_funct7,
    input  logic [2:0]           req1_funct3,
    input  logic [WORD_SIZE-1:0] req1_src1,
    input  logic [WORD_SIZE-1:0] req1_src2,
    output logic [6:0]           alu_funct7,
    output logic [2:0]           alu_funct3,
    output logic [WORD_SIZE-1:0] alu_source1,
    output logic [WORD_SIZE-1:0] alu_source2,
    input  logic [WORD_SIZE-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic                 busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       prio;
    logic       cap_id;
    logic       idle;

    // rst gating keeps both readies low while reset holds the FSM in IDLE
    assign idle       = (state == IDLE) && !rst;
    assign req0_ready = idle && req0_valid && (!req1_valid || !prio);
    assign req1_ready = idle && req1_valid && (!req0_valid || prio);
    assign rsp_valid  = state == RESP;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            cap_id      <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            alu_funct7  <= '0;
            alu_funct3  <= '0;
            alu_source1 <= '0;
            alu_source2 <= '0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    alu_funct7  <= req1_ready ? req1_funct7 : req0_funct7;
                    alu_funct3  <= req1_ready ? req1_funct3 : req0_funct3;
                    alu_source1 <= req1_ready ? req1_src1 : req0_src1;
                    alu_source2 <= req1_ready ? req1_src2 : req0_src2;
                    cap_id      <= req1_ready;
                    prio        <= req0_ready;
                    state       <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= cap_id;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench with an add/sub ALU model.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [6:0]   req0_funct7 = '0, req1_funct7 = '0;
    logic [2:0]   req0_funct3 = '0, req1_funct3 = '0;
    logic [W-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic [6:0]   alu_funct7;
    logic [2:0]   alu_funct3;
    logic [W-1:0] alu_source1, alu_source2, alu_result;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
    logic [W-1:0] rsp_result;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign alu_result = (alu_funct3 != 3'b000) ? '0 :
                        alu_funct7[5] ? alu_source1 - alu_source2 : alu_source1 + alu_source2;

    alu_arbiter #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct7(req0_funct7),
        .req0_funct3(req0_funct3), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct7(req1_funct7),
        .req1_funct3(req1_funct3), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
        .alu_source1(alu_source1), .alu_source2(alu_source2), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
        end
        vectors++;
        if ({rsp_valid, busy, rsp_id, rsp_result, alu_source1, alu_source2, alu_funct7, alu_funct3} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b b=%b id=%b r=%h s1=%h s2=%h", rsp_valid, busy, rsp_id, rsp_result, alu_source1, alu_source2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_add();
        req0_valid = 1'b1; req0_funct7 = 7'd0; req0_funct3 = 3'd0; req0_src1 = 5; req0_src2 = 3;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        #1;
        vectors++;
        if ({busy, rsp_valid, alu_source1, alu_source2} !== {1'b1, 1'b0, 32'd5, 32'd3}) begin
            miscompares++;
            $display("FAIL add_exec got b=%b v=%b s1=%0d s2=%0d want 1 0 5 3", busy, rsp_valid, alu_source1, alu_source2);
        end
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd8}) begin
            miscompares++;
            $display("FAIL add_resp got v=%b id=%b r=%0d want 1 0 8", rsp_valid, rsp_id, rsp_result);
        end
        step();
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL add_idle got v=%b b=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_single_sub();
        req1_valid = 1'b1; req1_funct7 = 7'b0100000; req1_funct3 = 3'd0; req1_src1 = 10; req1_src2 = 12;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL sub_ready got %b want 01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'hFFFF_FFFE}) begin
            miscompares++;
            $display("FAIL sub_resp got v=%b id=%b r=%h want 1 1 fffffffe", rsp_valid, rsp_id, rsp_result);
        end
        step();
    endtask

    task automatic test_contention();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        req0_valid = 1'b1; req0_funct7 = 7'd0; req0_src1 = 1;   req0_src2 = 1;
        req1_valid = 1'b1; req1_funct7 = 7'd0; req1_src1 = 100; req1_src2 = 50;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({req0_ready, req1_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL contention_grant%0d got %b want %b", i, {req0_ready, req1_ready}, (i % 2) ? 2'b01 : 2'b10);
            end
            step();
            step();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, i[0], (i % 2) ? 32'd150 : 32'd2}) begin
                miscompares++;
                $display("FAIL contention_resp%0d got v=%b id=%b r=%0d", i, rsp_valid, rsp_id, rsp_result);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_src1 = 7; req0_src2 = 9;
        req1_valid = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready} !== {1'b1, 1'b0, 32'd16, 2'b00}) begin
                miscompares++;
                $display("FAIL backpressure_hold%0d got v=%b id=%b r=%0d rdy=%b%b", i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        vectors++;
        if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL backpressure_release got v=%b b=%b rdy=%b%b want 0 0 01", rsp_valid, busy, req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_op();
        req1_valid = 1'b1; req1_funct7 = 7'b0100000; req1_funct3 = 3'd0; req1_src1 = 2; req1_src2 = 2;
        step();
        req1_valid = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_exec busy got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({rsp_valid, busy, rsp_id, rsp_result, alu_source1, alu_source2, alu_funct7, alu_funct3} !== '0) begin
            miscompares++;
            $display("FAIL midreset_async got v=%b b=%b id=%b r=%h s1=%h f7=%h", rsp_valid, busy, rsp_id, rsp_result, alu_source1, alu_funct7);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({rsp_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL midreset_after%0d got v=%b b=%b want 0 0", i, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_operand_isolation();
        req0_valid = 1'b1; req0_funct7 = 7'd0; req0_funct3 = 3'd0; req0_src1 = 20; req0_src2 = 22;
        step();
        req0_src1 = 999;
        #1;
        vectors++;
        if ({alu_source1, req0_ready} !== {32'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL isolation_exec got s1=%0d rdy=%b want 20 0", alu_source1, req0_ready);
        end
        step();
        vectors++;
        if ({rsp_valid, rsp_result, alu_source1, req0_ready} !== {1'b1, 32'd42, 32'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL isolation_resp got v=%b r=%0d s1=%0d rdy=%b want 1 42 20 0", rsp_valid, rsp_result, alu_source1, req0_ready);
        end
        req0_valid = 1'b0;
        step();
        vectors++;
        if ({busy, alu_source1} !== {1'b0, 32'd20}) begin
            miscompares++;
            $display("FAIL isolation_idle got b=%b s1=%0d want 0 20", busy, alu_source1);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_single_sub();
        test_contention();
        test_back_pressure();
        test_reset_mid_op();
        test_operand_isolation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WORD_SIZE, default 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an ALU operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_funct7 / req0_funct3  input  7 / 3  requester 0 ALU control fields.
REQ-007 req0_src1 / req0_src2  input  WORD_SIZE each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_funct7, req1_funct3, req1_src1, req1_src2: identical to REQ-004..007, for requester 1.
REQ-009 alu_funct7 / alu_funct3  output  7 / 3  control fields driven to the shared combinational ALU.
REQ-010 alu_source1 / alu_source2  output  WORD_SIZE each  operands driven to the shared ALU.
REQ-011 alu_result  input  WORD_SIZE  combinational result returned by the shared ALU.
REQ-012 rsp_valid  output  1  response holds a completed result.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  requester index (0/1) that owns the response.
REQ-015 rsp_result  output  WORD_SIZE  registered ALU result.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 IDLE: if neither valid, stay IDLE; else grant one requester, capture its funct7, funct3, src1, src2 and its index into internal registers, go to EXEC.
REQ-019 Grant: only one valid -> that requester, regardless of priority; both valid -> requester named by priority pointer prio.
REQ-020 reqN_ready is combinational: high only in IDLE when reqN_valid is high and N is granted; at most one ready high per cycle; handshake completes on valid&&ready at the clock edge.
REQ-021 After each grant to N, prio is set to the other requester (round-robin); prio is unchanged in cycles without a grant.
REQ-022 alu_funct7, alu_funct3, alu_source1, alu_source2 are driven from the captured registers in all states, never directly from request inputs.
REQ-023 EXEC lasts exactly one cycle: capture alu_result into rsp_result and the captured index into rsp_id, go to RESP.
REQ-024 RESP: rsp_valid high; rsp_result and rsp_id stable; on rsp_ready high go to IDLE; otherwise hold RESP indefinitely.
REQ-025 rsp_valid is low in IDLE and EXEC; no new request is accepted in EXEC or RESP, including the RESP cycle in which rsp_ready is high.
REQ-026 Latency: request accepted at edge k -> rsp_valid high from the cycle after edge k+1; minimum 3 cycles per operation with rsp_ready tied high.
REQ-027 Request inputs that change or drop valid while not ready have no effect; a requester dropping valid before being granted is legal.
REQ-028 Arithmetic is performed only by the external ALU; the block does not alter widths or values of operands or result.

Reset
REQ-029 rst high asynchronously forces state IDLE, prio=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, captured funct/operand registers=0, hence alu_* outputs=0.
REQ-030 rst asserted during EXEC or RESP abandons the in-flight operation; no response is produced for it after reset release.
REQ-031 Both req*_ready are low while rst is high; first grant after reset release follows REQ-019 with prio=0.

Verification
REQ-032 Single op: req0 valid, funct3=000, funct7=0, src1=5, src2=3, ALU model add/sub -> req0_ready same cycle, rsp_valid two edges later, rsp_result=8, rsp_id=0.
REQ-033 Subtract: req1 valid, funct7=0100000, funct3=000, src1=10, src2=12 -> rsp_result=0xFFFFFFFE, rsp_id=1.
REQ-034 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_id matches its grant.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_result, rsp_id stable and both readies low; rsp_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-operation: assert rst during EXEC -> all outputs zero immediately (no clock edge needed); after release no rsp_valid without a new request.
REQ-037 Operand isolation: change req0_src1 while in EXEC/RESP -> alu_source1 and rsp_result unaffected.
